gate_sweep_checker: RTL and testbench

- Synthesizable exhaustive truth-table sweeper for N-input combinational gates; replaces hand-written per-gate stimulus benches.
- Drives every input combination to a DUT, holds each for HOLD_CYCLES, and compares the DUT output against a built-in reference for the selected gate mode.
- Reports error count, first failing vector and pass/done status; sits beside any N-input gate in the board-level test wrapper.

---
 rtl/gate_sweep_pkg.sv | 53 +++++
 rtl/gate_ref_model.sv | 17 +
 rtl/gate_sweep_checker.sv | 138 +++++++++++++
 tb/tb_gate_sweep_checker.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate truth-table sweeper: gate mode codes, FSM states and the
// reference gate function used to judge the DUT output.
package gate_sweep_pkg;

  localparam int unsigned MAX_N = 16;

  localparam logic [2:0] MODE_AND  = 3'd0;
  localparam logic [2:0] MODE_OR   = 3'd1;
  localparam logic [2:0] MODE_NAND = 3'd2;
  localparam logic [2:0] MODE_NOR  = 3'd3;
  localparam logic [2:0] MODE_XOR  = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic logic mode_valid(input logic [2:0] mode);
    return mode <= MODE_XNOR;
  endfunction

  // Only the low n bits of vec take part; reserved modes evaluate to 0.
  function automatic logic ref_out(input logic [MAX_N-1:0] vec, input int unsigned n,
                                   input logic [2:0] mode);
    logic and_r;
    logic or_r;
    logic xor_r;
    logic y;
    and_r = 1'b1;
    or_r  = 1'b0;
    xor_r = 1'b0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        and_r = and_r & vec[i];
        or_r  = or_r | vec[i];
        xor_r = xor_r ^ vec[i];
      end
    end
    case (mode)
      MODE_AND:  y = and_r;
      MODE_OR:   y = or_r;
      MODE_NAND: y = ~and_r;
      MODE_NOR:  y = ~or_r;
      MODE_XOR:  y = xor_r;
      MODE_XNOR: y = ~xor_r;
      default:   y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference gate: expected output of an N-input gate of the selected mode.
module gate_ref_model
  import gate_sweep_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] vec,
  input  logic [2:0]   mode,
  output logic         y
);

  logic [MAX_N-1:0] vec_ext;

  assign vec_ext = MAX_N'(vec);
  assign y       = ref_out(vec_ext, N, mode);

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive truth-table sweeper for an N-input gate with error count and first-fail capture.
// Define GATE_SWEEP_GRAY_EN to sweep in reflected Gray order instead of binary order.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  output logic [N-1:0]     vec_out,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [N-1:0]     fail_vec,
  output logic             fail_valid
);

  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [N-1:0]     cnt_q, cnt_d;
  logic [N-1:0]     vec_q, vec_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [2:0]       mode_q, mode_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [N-1:0]     fail_vec_q, fail_vec_d;
  logic             fail_valid_q, fail_valid_d;
  logic             pass_q, pass_d;
  logic             exp_y;

  // Sweep position to stimulus; Gray order toggles exactly one input per step.
  function automatic logic [N-1:0] order(input logic [N-1:0] c);
`ifdef GATE_SWEEP_GRAY_EN
    return c ^ (c >> 1);
`else
    return c;
`endif
  endfunction

  gate_ref_model #(
    .N(N)
  ) u_ref (
    .vec  (vec_q),
    .mode (mode_q),
    .y    (exp_y)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    vec_d        = vec_q;
    hold_d       = hold_q;
    mode_d       = mode_q;
    err_d        = err_q;
    fail_vec_d   = fail_vec_q;
    fail_valid_d = fail_valid_q;
    pass_d       = pass_q;
    case (state_q)
      StIdle, StDone: begin
        if (start && mode_valid(mode)) begin
          state_d      = StRun;
          mode_d       = mode;
          cnt_d        = '0;
          vec_d        = order('0);
          hold_d       = '0;
          err_d        = '0;
          fail_vec_d   = '0;
          fail_valid_d = 1'b0;
          pass_d       = 1'b0;
        end
      end
      StRun: begin
        if (hold_q == HoldLast) begin
          if (dut_y != exp_y) begin
            if (err_q != '1) begin
              err_d = err_q + ERR_W'(1);
            end
            if (!fail_valid_q) begin
              fail_vec_d   = vec_q;
              fail_valid_d = 1'b1;
            end
          end
          if (cnt_q == '1) begin
            state_d = StDone;
            pass_d  = (err_d == '0);
          end else begin
            cnt_d  = cnt_q + N'(1);
            vec_d  = order(cnt_d);
            hold_d = '0;
          end
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      vec_q        <= '0;
      hold_q       <= '0;
      mode_q       <= '0;
      err_q        <= '0;
      fail_vec_q   <= '0;
      fail_valid_q <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vec_q        <= vec_d;
      hold_q       <= hold_d;
      mode_q       <= mode_d;
      err_q        <= err_d;
      fail_vec_q   <= fail_vec_d;
      fail_valid_q <= fail_valid_d;
      pass_q       <= pass_d;
    end
  end

  assign vec_out    = vec_q;
  assign busy       = (state_q == StRun);
  assign done       = (state_q == StDone);
  assign pass       = pass_q & (state_q == StDone);
  assign err_cnt    = err_q;
  assign fail_vec   = fail_vec_q;
  assign fail_valid = fail_valid_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: table of full sweeps on a 4-input instance plus
// hand sequences for reserved modes, mid-sweep reset and counter saturation on a 3-input one.
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  logic rst;

  logic       start4, start3;
  logic [2:0] mode4, mode3;
  logic [3:0] vec4, fv4;
  logic [2:0] vec3, fv3;
  logic       y4, y3;
  logic       busy4, done4, pass4, fvv4;
  logic       busy3, done3, pass3, fvv3;
  logic [7:0] err4;
  logic [1:0] err3;

  int         checks = 0;
  int         errors = 0;
  logic [2:0] gate_sel;
  int         dut_kind;

  typedef struct {
    logic [2:0] mode;
    int         kind;
    bit         disturb;
    int         err;
    bit         fvalid;
    logic [3:0] fvec;
    bit         pass;
  } row_t;

  row_t tbl[7];

  always #5 clk = ~clk;

  gate_sweep_checker #(.N(4), .HOLD_CYCLES(2), .ERR_W(8)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .start      (start4),
    .mode       (mode4),
    .vec_out    (vec4),
    .dut_y      (y4),
    .busy       (busy4),
    .done       (done4),
    .pass       (pass4),
    .err_cnt    (err4),
    .fail_vec   (fv4),
    .fail_valid (fvv4)
  );

  gate_sweep_checker #(.N(3), .HOLD_CYCLES(1), .ERR_W(2)) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .start      (start3),
    .mode       (mode3),
    .vec_out    (vec3),
    .dut_y      (y3),
    .busy       (busy3),
    .done       (done3),
    .pass       (pass3),
    .err_cnt    (err3),
    .fail_vec   (fv3),
    .fail_valid (fvv3)
  );

  function automatic logic tb_ref(input logic [3:0] v, input logic [2:0] g);
    case (g)
      3'd0:    return &v;
      3'd1:    return |v;
      3'd2:    return ~&v;
      3'd3:    return ~|v;
      3'd4:    return ^v;
      3'd5:    return ~^v;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] exp_vec(input int k);
    logic [3:0] c;
    c = 4'(k);
`ifdef GATE_SWEEP_GRAY_EN
    return c ^ (c >> 1);
`else
    return c;
`endif
  endfunction

  // DUT models: 0 ideal gate, 1 stuck-at-1, 2 stuck-at-0, 3 OR gate regardless of mode
  always_comb begin
    case (dut_kind)
      0:       y4 = tb_ref(vec4, gate_sel);
      1:       y4 = 1'b1;
      2:       y4 = 1'b0;
      default: y4 = |vec4;
    endcase
  end
  assign y3 = &vec3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run4(input logic [2:0] m, input int kind, input bit disturb,
                      output int cycles, output bit seq_ok);
    gate_sel = m;
    dut_kind = kind;
    @(negedge clk);
    mode4  = m;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    cycles = 0;
    seq_ok = 1'b1;
    while (!done4 && cycles < 200) begin
      if (cycles < 32 && vec4 !== exp_vec(cycles / 2)) seq_ok = 1'b0;
      if (!busy4) seq_ok = 1'b0;
      // vector 5 spans cycles 10..11
      if (disturb && cycles == 10) begin
        start4 = 1'b1;
        mode4  = 3'd0;
      end else begin
        start4 = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    start4 = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit ok;
    rst      = 1'b1;
    start4   = 1'b0;
    start3   = 1'b0;
    mode4    = 3'd0;
    mode3    = 3'd0;
    gate_sel = 3'd0;
    dut_kind = 0;

    tbl[0] = '{3'd2, 0, 1'b0, 0, 1'b0, 4'h0, 1'b1};
    tbl[1] = '{3'd2, 1, 1'b0, 1, 1'b1, 4'hF, 1'b0};
    tbl[2] = '{3'd3, 0, 1'b1, 0, 1'b0, 4'h0, 1'b1};
    tbl[3] = '{3'd4, 0, 1'b0, 0, 1'b0, 4'h0, 1'b1};
    tbl[4] = '{3'd0, 3, 1'b0, 14, 1'b1, 4'h1, 1'b0};
    tbl[5] = '{3'd5, 0, 1'b0, 0, 1'b0, 4'h0, 1'b1};
    tbl[6] = '{3'd1, 2, 1'b0, 15, 1'b1, 4'h1, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_vec", vec4, 0);
    check("rst_flags", {busy4, done4, pass4, fvv4}, 0);
    check("rst_err", err4, 0);
    check("rst_fvec", fv4, 0);
    rst = 1'b0;

    // Reserved mode from IDLE must not start a sweep.
    @(negedge clk);
    mode4  = 3'd7;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("rsvd_idle_busy", busy4, 0);
    repeat (3) @(negedge clk);
    check("rsvd_idle_state", {busy4, done4}, 0);

    for (int i = 0; i < 7; i++) begin
      run4(tbl[i].mode, tbl[i].kind, tbl[i].disturb, cyc, ok);
      check($sformatf("row%0d_cycles", i), cyc, 32);
      check($sformatf("row%0d_seq", i), ok, 1);
      check($sformatf("row%0d_err", i), err4, tbl[i].err);
      check($sformatf("row%0d_fvalid", i), fvv4, tbl[i].fvalid);
      check($sformatf("row%0d_fvec", i), fv4, tbl[i].fvec);
      check($sformatf("row%0d_pass", i), pass4, tbl[i].pass);
      check($sformatf("row%0d_busy", i), busy4, 0);
    end

    // Reserved mode from DONE: state unchanged.
    mode4  = 3'd6;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    check("rsvd_done_state", {busy4, done4}, 2'b01);
    check("rsvd_done_err", err4, 15);

    // Reset at vector 9 with errors already counted.
    gate_sel = 3'd0;
    dut_kind = 3;
    mode4    = 3'd0;
    start4   = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (18) @(negedge clk);
    check("mid_vec", vec4, exp_vec(9));
    check("mid_err", err4, 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_vec", vec4, 0);
    check("abort_flags", {busy4, done4, pass4, fvv4}, 0);
    check("abort_err", err4, 0);
    check("abort_fvec", fv4, 0);

    run4(3'd2, 0, 1'b0, cyc, ok);
    check("post_rst_cycles", cyc, 32);
    check("post_rst_seq", ok, 1);
    check("post_rst_pass", pass4, 1);

    // N=3, HOLD=1: AND3 judged as NAND fails every vector, counter saturates.
    @(negedge clk);
    mode3  = 3'd2;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    cyc    = 0;
    while (!done3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("n3_cycles", cyc, 8);
    check("n3_err", err3, 3);
    check("n3_fvec", fv3, 0);
    check("n3_fvalid", fvv3, 1);
    check("n3_pass", pass3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
